// File: rtl/ifu_fetch_if.sv
// Instruction-memory request/response channel between the fetch unit (master)
// and instruction memory (slave). Both directions use valid/ready handshakes.
interface ifu_fetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
);
    // Handshake rule: a transfer happens on a rising clock edge where valid and
    // ready are both high; valid may not depend combinationally on ready.
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [ADDR_WIDTH-1:0] imem_req_addr;
    logic                  imem_resp_valid;
    logic                  imem_resp_ready;
    logic [INST_WIDTH-1:0] imem_resp_data;
    logic                  imem_resp_err;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        output imem_resp_ready,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        input  imem_resp_err
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        input  imem_resp_ready,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        output imem_resp_err
    );
endinterface

// File: rtl/ifu_fetch.sv
// Single-issue instruction fetch unit: owns the PC and fetches one instruction at a time.
// Optional IFU_PERF_CNT_EN adds 64-bit committed-instruction and stall counters.
module ifu_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] PC_RESET   = ADDR_WIDTH'(32'h8000_0000)
) (
    input  logic                  clk,
    input  logic                  rst,
    ifu_fetch_if.master           imem,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [INST_WIDTH-1:0] inst,
    output logic                  inst_valid,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic                  pc_w_en,
    output logic                  fetch_err,
    output logic                  fetch_err_misal,
`ifdef IFU_PERF_CNT_EN
    output logic [63:0]           perf_inst_cnt,
    output logic [63:0]           perf_stall_cnt,
`endif
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_RESP  = 2'd1,
        S_VALID = 2'd2,
        S_ERR   = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic                  misal_q, misal_d;
    logic                  req_valid_q, resp_ready_q, inst_valid_q, fetch_err_q;
    logic                  commit;

    assign commit = (state_q == S_VALID) && pc_w_en;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        misal_d = misal_q;
        case (state_q)
            S_REQ: begin
                if (imem.imem_req_ready) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (imem.imem_resp_valid) begin
                    inst_d = imem.imem_resp_data;
                    if (imem.imem_resp_err) begin
                        state_d = S_ERR;
                        misal_d = 1'b0;
                    end else begin
                        state_d = S_VALID;
                    end
                end
            end
            S_VALID: begin
                // A misaligned target is trapped here; the PC keeps the faulting instruction's address.
                if (pc_w_en) begin
                    if (pc_in[1:0] == 2'b00) begin
                        pc_d    = pc_in;
                        state_d = S_REQ;
                    end else begin
                        state_d = S_ERR;
                        misal_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    // Handshake/status outputs are registered from the next state so they stay glitch-free.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_REQ;
            pc_q         <= PC_RESET;
            inst_q       <= '0;
            misal_q      <= 1'b0;
            req_valid_q  <= 1'b1;
            resp_ready_q <= 1'b0;
            inst_valid_q <= 1'b0;
            fetch_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            misal_q      <= misal_d;
            req_valid_q  <= (state_d == S_REQ);
            resp_ready_q <= (state_d == S_RESP);
            inst_valid_q <= (state_d == S_VALID);
            fetch_err_q  <= (state_d == S_ERR);
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [63:0] perf_inst_q, perf_inst_d;
    logic [63:0] perf_stall_q, perf_stall_d;
    logic        stall;

    assign stall = ((state_q == S_REQ)  && !imem.imem_req_ready) ||
                   ((state_q == S_RESP) && !imem.imem_resp_valid);

    always_comb begin
        perf_inst_d  = perf_inst_q  + {63'd0, commit};
        perf_stall_d = perf_stall_q + {63'd0, stall};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_inst_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_inst_q  <= perf_inst_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_inst_cnt  = perf_inst_q;
    assign perf_stall_cnt = perf_stall_q;
`else
    logic unused_commit;
    assign unused_commit = commit;
`endif

    assign imem.imem_req_valid  = req_valid_q;
    assign imem.imem_req_addr   = pc_q;
    assign imem.imem_resp_ready = resp_ready_q;
    assign pc_out               = pc_q;
    assign inst                 = inst_q;
    assign inst_valid           = inst_valid_q;
    assign fetch_err            = fetch_err_q;
    assign fetch_err_misal      = misal_q;
    assign dbg_state            = state_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: randomized memory timing and commit targets
// checked against a PC/instruction-queue reference model.
module tb_ifu_fetch;
    localparam logic [31:0] PC_RST = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_out, inst, pc_in;
    logic        inst_valid, pc_w_en, fetch_err, fetch_err_misal;
    logic [1:0]  dbg_state;
`ifdef IFU_PERF_CNT_EN
    logic [63:0] perf_inst_cnt, perf_stall_cnt;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_q[$];
    longint      exp_icnt;

    always #5 clk = ~clk;

    ifu_fetch_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) imem_if ();

    ifu_fetch #(.ADDR_WIDTH(32), .INST_WIDTH(32), .PC_RESET(PC_RST)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem            (imem_if.master),
        .pc_out          (pc_out),
        .inst            (inst),
        .inst_valid      (inst_valid),
        .pc_in           (pc_in),
        .pc_w_en         (pc_w_en),
        .fetch_err       (fetch_err),
        .fetch_err_misal (fetch_err_misal),
`ifdef IFU_PERF_CNT_EN
        .perf_inst_cnt   (perf_inst_cnt),
        .perf_stall_cnt  (perf_stall_cnt),
`endif
        .dbg_state       (dbg_state)
    );

    // Inputs change and outputs are sampled at the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst                     = 1'b0;
        pc_w_en                 = 1'b0;
        pc_in                   = '0;
        imem_if.imem_req_ready  = 1'b0;
        imem_if.imem_resp_valid = 1'b0;
        imem_if.imem_resp_data  = '0;
        imem_if.imem_resp_err   = 1'b0;
        cyc();
        rst      = 1'b1;
        exp_pc   = PC_RST;
        exp_icnt = 0;
        exp_q.delete();
    endtask

    // Runs one fetch from S_REQ: rd cycles of req_ready=0, sd cycles of resp_valid=0.
    task automatic do_fetch(input int rd, input int sd, input logic [31:0] data,
                            input logic err, input bit noise);
        logic [31:0] got;
        exp_q.push_back(data);
        checks++;
        if ({imem_if.imem_req_valid, inst_valid} !== 2'b10 || imem_if.imem_req_addr !== exp_pc) begin
            errors++;
            $display("FAIL req_start: valid/inst_valid=%b addr=%h, want 10 addr=%h",
                     {imem_if.imem_req_valid, inst_valid}, imem_if.imem_req_addr, exp_pc);
        end
        for (int i = 0; i < rd; i++) begin
            imem_if.imem_req_ready  = 1'b0;
            imem_if.imem_resp_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            imem_if.imem_resp_data  = $urandom;
            pc_w_en = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            pc_in   = $urandom;
            cyc();
            checks++;
            if ({imem_if.imem_req_valid, inst_valid} !== 2'b10 || imem_if.imem_req_addr !== exp_pc) begin
                errors++;
                $display("FAIL req_hold: valid/inst_valid=%b addr=%h, want 10 addr=%h",
                         {imem_if.imem_req_valid, inst_valid}, imem_if.imem_req_addr, exp_pc);
            end
        end
        imem_if.imem_req_ready  = 1'b1;
        imem_if.imem_resp_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        imem_if.imem_resp_data  = $urandom;
        cyc();
        imem_if.imem_req_ready = 1'b0;
        for (int i = 0; i <= sd; i++) begin
            checks++;
            if ({imem_if.imem_resp_ready, imem_if.imem_req_valid, inst_valid} !== 3'b100 || pc_out !== exp_pc) begin
                errors++;
                $display("FAIL resp_wait: rr/rv/iv=%b pc=%h, want 100 pc=%h",
                         {imem_if.imem_resp_ready, imem_if.imem_req_valid, inst_valid}, pc_out, exp_pc);
            end
            if (i < sd) begin
                imem_if.imem_resp_valid = 1'b0;
                imem_if.imem_resp_data  = $urandom;
                pc_w_en = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                pc_in   = $urandom;
                cyc();
            end
        end
        imem_if.imem_resp_valid = 1'b1;
        imem_if.imem_resp_data  = data;
        imem_if.imem_resp_err   = err;
        pc_w_en = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        cyc();
        imem_if.imem_resp_valid = 1'b0;
        imem_if.imem_resp_err   = 1'b0;
        pc_w_en                 = 1'b0;
        got = exp_q.pop_front();
        checks++;
        if (!err) begin
            if ({inst_valid, fetch_err, imem_if.imem_req_valid, imem_if.imem_resp_ready} !== 4'b1000 ||
                inst !== got || pc_out !== exp_pc) begin
                errors++;
                $display("FAIL inst_out: iv/err/rqv/rsr=%b inst=%h pc=%h, want 1000 inst=%h pc=%h",
                         {inst_valid, fetch_err, imem_if.imem_req_valid, imem_if.imem_resp_ready},
                         inst, pc_out, got, exp_pc);
            end
        end else begin
            if ({inst_valid, fetch_err, fetch_err_misal, imem_if.imem_req_valid} !== 4'b0100 || inst !== got) begin
                errors++;
                $display("FAIL access_fault: iv/err/misal/rqv=%b inst=%h, want 0100 inst=%h",
                         {inst_valid, fetch_err, fetch_err_misal, imem_if.imem_req_valid}, inst, got);
            end
        end
    endtask

    task automatic commit(input logic [31:0] npc);
        logic [31:0] old_pc;
        old_pc  = exp_pc;
        pc_w_en = 1'b1;
        pc_in   = npc;
        cyc();
        pc_w_en = 1'b0;
        checks++;
        if (npc[1:0] == 2'b00) begin
            exp_pc = npc;
            exp_icnt++;
            if ({imem_if.imem_req_valid, inst_valid, fetch_err} !== 3'b100 || imem_if.imem_req_addr !== npc) begin
                errors++;
                $display("FAIL commit: rqv/iv/err=%b addr=%h, want 100 addr=%h",
                         {imem_if.imem_req_valid, inst_valid, fetch_err}, imem_if.imem_req_addr, npc);
            end
        end else begin
            if ({fetch_err, fetch_err_misal, imem_if.imem_req_valid, inst_valid} !== 4'b1100 || pc_out !== old_pc) begin
                errors++;
                $display("FAIL misal_commit: err/misal/rqv/iv=%b pc=%h, want 1100 pc=%h",
                         {fetch_err, fetch_err_misal, imem_if.imem_req_valid, inst_valid}, pc_out, old_pc);
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({imem_if.imem_req_valid, imem_if.imem_resp_ready, inst_valid, fetch_err, fetch_err_misal} !== 5'b10000 ||
            pc_out !== PC_RST || inst !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: flags=%b pc=%h inst=%h, want 10000 pc=%h inst=0",
                     {imem_if.imem_req_valid, imem_if.imem_resp_ready, inst_valid, fetch_err, fetch_err_misal},
                     pc_out, inst, PC_RST);
        end
`ifdef IFU_PERF_CNT_EN
        checks++;
        if (perf_inst_cnt !== 64'd0 || perf_stall_cnt !== 64'd0) begin
            errors++;
            $display("FAIL reset_perf: inst=%0d stall=%0d, want 0 0", perf_inst_cnt, perf_stall_cnt);
        end
`endif
    endtask

    task automatic test_basic();
        do_fetch(0, 0, 32'h0010_0073, 1'b0, 1'b0);
        commit(32'h8000_0004);
    endtask

    task automatic test_stall();
`ifdef IFU_PERF_CNT_EN
        logic [63:0] s0;
        s0 = perf_stall_cnt;
`endif
        do_fetch(5, 3, 32'h1234_5678, 1'b0, 1'b0);
`ifdef IFU_PERF_CNT_EN
        checks++;
        if (perf_stall_cnt - s0 !== 64'd8) begin
            errors++;
            $display("FAIL stall_cnt: delta=%0d, want 8", perf_stall_cnt - s0);
        end
`endif
        commit(32'h8000_0100);
    endtask

    task automatic test_back_to_back();
        do_fetch(0, 0, 32'hdead_beef, 1'b0, 1'b0);
        pc_w_en = 1'b1;
        pc_in   = 32'h8000_0200;
        cyc();
        pc_in   = 32'h8000_0300;
        cyc();
        pc_w_en = 1'b0;
        exp_pc  = 32'h8000_0200;
        exp_icnt++;
        checks++;
        if ({imem_if.imem_req_valid, inst_valid} !== 2'b10 || imem_if.imem_req_addr !== exp_pc) begin
            errors++;
            $display("FAIL back_to_back: rqv/iv=%b addr=%h, want 10 addr=%h",
                     {imem_if.imem_req_valid, inst_valid}, imem_if.imem_req_addr, exp_pc);
        end
    endtask

    task automatic test_random();
        logic [31:0] tmp, hold_inst;
        int          hold;
        for (int n = 0; n < 25; n++) begin
            hold_inst = $urandom;
            do_fetch($urandom_range(0, 3), $urandom_range(0, 3), hold_inst, 1'b0, 1'b1);
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                imem_if.imem_resp_valid = 1'($urandom_range(0, 1));
                imem_if.imem_resp_data  = $urandom;
                imem_if.imem_req_ready  = 1'($urandom_range(0, 1));
                cyc();
                checks++;
                if (inst_valid !== 1'b1 || inst !== hold_inst || pc_out !== exp_pc) begin
                    errors++;
                    $display("FAIL hold_valid: iv=%b inst=%h pc=%h, want 1 inst=%h pc=%h",
                             inst_valid, inst, pc_out, hold_inst, exp_pc);
                end
            end
            imem_if.imem_resp_valid = 1'b0;
            imem_if.imem_req_ready  = 1'b0;
            tmp = $urandom;
            commit({tmp[31:2], 2'b00});
        end
`ifdef IFU_PERF_CNT_EN
        checks++;
        if (perf_inst_cnt !== 64'(exp_icnt)) begin
            errors++;
            $display("FAIL inst_cnt: got=%0d want=%0d", perf_inst_cnt, exp_icnt);
        end
`endif
    endtask

    task automatic test_error();
        do_fetch(1, 1, 32'hbad0_0001, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            imem_if.imem_req_ready  = 1'b1;
            imem_if.imem_resp_valid = 1'($urandom_range(0, 1));
            pc_w_en = 1'($urandom_range(0, 1));
            pc_in   = $urandom;
            cyc();
            checks++;
            if ({imem_if.imem_req_valid, fetch_err, fetch_err_misal} !== 3'b010) begin
                errors++;
                $display("FAIL err_sticky: rqv/err/misal=%b, want 010",
                         {imem_if.imem_req_valid, fetch_err, fetch_err_misal});
            end
        end
        apply_reset();
        checks++;
        if ({fetch_err, fetch_err_misal, imem_if.imem_req_valid} !== 3'b001 || pc_out !== PC_RST) begin
            errors++;
            $display("FAIL err_clear: err/misal/rqv=%b pc=%h, want 001 pc=%h",
                     {fetch_err, fetch_err_misal, imem_if.imem_req_valid}, pc_out, PC_RST);
        end
    endtask

    task automatic test_misal();
        do_fetch(0, 0, 32'h0000_0013, 1'b0, 1'b0);
        commit(32'h8000_0006);
        cyc();
        checks++;
        if ({fetch_err, fetch_err_misal, imem_if.imem_req_valid} !== 3'b110 || pc_out !== PC_RST) begin
            errors++;
            $display("FAIL misal_sticky: err/misal/rqv=%b pc=%h, want 110 pc=%h",
                     {fetch_err, fetch_err_misal, imem_if.imem_req_valid}, pc_out, PC_RST);
        end
        apply_reset();
    endtask

    task automatic test_reset_mid();
        do_fetch(0, 0, 32'h0000_0093, 1'b0, 1'b0);
        commit(32'h8000_0040);
        imem_if.imem_req_ready = 1'b1;
        cyc();
        imem_if.imem_req_ready = 1'b0;
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        exp_pc = PC_RST;
        exp_q.delete();
        imem_if.imem_resp_valid = 1'b1;
        imem_if.imem_resp_data  = 32'hffff_ffff;
        cyc();
        imem_if.imem_resp_valid = 1'b0;
        checks++;
        if ({imem_if.imem_req_valid, imem_if.imem_resp_ready, inst_valid} !== 3'b100 ||
            imem_if.imem_req_addr !== PC_RST || inst !== 32'h0) begin
            errors++;
            $display("FAIL stale_resp: rqv/rsr/iv=%b addr=%h inst=%h, want 100 addr=%h inst=0",
                     {imem_if.imem_req_valid, imem_if.imem_resp_ready, inst_valid},
                     imem_if.imem_req_addr, inst, PC_RST);
        end
        do_fetch(0, 0, 32'h0010_0073, 1'b0, 1'b0);
    endtask

    initial begin
        pc_w_en = 1'b0;
        pc_in   = '0;
        imem_if.imem_req_ready  = 1'b0;
        imem_if.imem_resp_valid = 1'b0;
        imem_if.imem_resp_data  = '0;
        imem_if.imem_resp_err   = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_random();
        test_error();
        test_misal();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
